path_metric_bank: RTL and testbench

- Parametrised path-metric storage stage of the Viterbi decoder; sits between the add-compare-select (ACS) array and traceback.
- Registers NUM_STATES metrics per trellis step, with frame-start initialisation and in-place normalisation (subtract-minimum) to prevent overflow.
- Reports the winning (minimum-metric) state each step for traceback start selection.

---
 rtl/viterbi_pkg.sv | 23 ++
 rtl/pm_argmin_tree.sv | 34 +++
 rtl/path_metric_bank.sv | 99 +++++++++
 tb/tb_path_metric_bank.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared Viterbi decoder types, constants and path-metric init helper
package viterbi_pkg;

    localparam int PM_INIT_ZERO = 0;
    localparam int PM_MAX_BITS  = 1024;

    typedef enum logic {PMB_IDLE, PMB_RUN} pmb_state_t;

    // State 0 starts at PM_INIT_ZERO, every other state at all-ones, so traceback
    // from a fresh frame is anchored to the known encoder start state.
    function automatic logic [PM_MAX_BITS-1:0] pm_init_pattern(input int num_states, input int pm_width);
        logic [PM_MAX_BITS-1:0] v;
        v = '0;
        for (int b = 0; b < PM_MAX_BITS; b++) begin
            if (b < pm_width)
                v[b] = ((PM_INIT_ZERO >> b) & 1) != 0;
            else if (b < num_states * pm_width)
                v[b] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/pm_argmin_tree.sv
// rtl/pm_argmin_tree.sv - combinational minimum/argmin reduction tree, lowest index wins ties
module pm_argmin_tree #(
    parameter int NUM_STATES = 4,
    parameter int PM_WIDTH   = 8,
    parameter int IDX_W      = $clog2(NUM_STATES)
) (
    input  logic [NUM_STATES*PM_WIDTH-1:0] pm,
    output logic [PM_WIDTH-1:0]            min_pm,
    output logic [IDX_W-1:0]               min_idx
);

    logic [PM_WIDTH-1:0] node_pm  [NUM_STATES];
    logic [IDX_W-1:0]    node_idx [NUM_STATES];

    // Pairwise reduction by stride; the left operand always has the lower index,
    // so a strict compare keeps it on ties.
    always_comb begin
        for (int k = 0; k < NUM_STATES; k++) begin
            node_pm[k]  = pm[k*PM_WIDTH +: PM_WIDTH];
            node_idx[k] = IDX_W'(k);
        end
        for (int s = 1; s < NUM_STATES; s = s * 2) begin
            for (int i = 0; i + s < NUM_STATES; i = i + 2 * s) begin
                if (node_pm[i+s] < node_pm[i]) begin
                    node_pm[i]  = node_pm[i+s];
                    node_idx[i] = node_idx[i+s];
                end
            end
        end
        min_pm  = node_pm[0];
        min_idx = node_idx[0];
    end

endmodule

// File: rtl/path_metric_bank.sv
// rtl/path_metric_bank.sv - Viterbi path-metric register bank with normalisation; PATH_METRIC_NORM_CNT_EN enables o_norm_cnt
module path_metric_bank
    import viterbi_pkg::*;
#(
    parameter int NUM_STATES  = 4,
    parameter int PM_WIDTH    = 8,
    parameter int NORM_THRESH = 2**(PM_WIDTH-1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic                           i_valid,
    input  logic [NUM_STATES*PM_WIDTH-1:0] i_pm,
    output logic [NUM_STATES*PM_WIDTH-1:0] o_pm,
    output logic                           o_valid,
    output logic [$clog2(NUM_STATES)-1:0]  o_min_state,
    output logic [PM_WIDTH-1:0]            o_min_pm,
    output logic                           o_norm_evt,
    output logic [15:0]                    o_norm_cnt
);

    localparam int IDX_W   = $clog2(NUM_STATES);
    localparam int PM_BITS = NUM_STATES * PM_WIDTH;
    localparam logic [PM_BITS-1:0]  PM_INIT = PM_BITS'(pm_init_pattern(NUM_STATES, PM_WIDTH));
    localparam logic [PM_WIDTH:0]   THRESH  = (PM_WIDTH+1)'(NORM_THRESH);

    pmb_state_t           state;
    logic [PM_WIDTH-1:0]  step_min;
    logic [IDX_W-1:0]     step_idx;
    logic                 step_norm;
    logic                 accept;
    logic [PM_BITS-1:0]   pm_next;

    pm_argmin_tree #(
        .NUM_STATES (NUM_STATES),
        .PM_WIDTH   (PM_WIDTH),
        .IDX_W      (IDX_W)
    ) u_argmin (
        .pm      (i_pm),
        .min_pm  (step_min),
        .min_idx (step_idx)
    );

    assign step_norm = {1'b0, step_min} >= THRESH;
    assign accept    = (state == PMB_RUN) && i_valid && !i_start;

    // Subtracting the step minimum cannot underflow, so no guard is needed.
    always_comb begin
        pm_next = '0;
        for (int k = 0; k < NUM_STATES; k++) begin
            pm_next[k*PM_WIDTH +: PM_WIDTH] = step_norm ? i_pm[k*PM_WIDTH +: PM_WIDTH] - step_min
                                                        : i_pm[k*PM_WIDTH +: PM_WIDTH];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= PMB_IDLE;
            o_pm        <= PM_INIT;
            o_valid     <= 1'b0;
            o_norm_evt  <= 1'b0;
            o_min_state <= '0;
            o_min_pm    <= '0;
        end else begin
            o_valid    <= 1'b0;
            o_norm_evt <= 1'b0;
            if (i_start) begin
                state       <= PMB_RUN;
                o_pm        <= PM_INIT;
                o_min_state <= '0;
                o_min_pm    <= '0;
            end else if (accept) begin
                o_pm        <= pm_next;
                o_min_state <= step_idx;
                o_min_pm    <= step_norm ? '0 : step_min;
                o_valid     <= 1'b1;
                o_norm_evt  <= step_norm;
            end
        end
    end

`ifdef PATH_METRIC_NORM_CNT_EN
    logic [15:0] norm_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            norm_cnt <= '0;
        else if (i_start)
            norm_cnt <= '0;
        else if (accept && step_norm && norm_cnt != 16'hFFFF)
            norm_cnt <= norm_cnt + 16'd1;
    end

    assign o_norm_cnt = norm_cnt;
`else
    assign o_norm_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_path_metric_bank.sv
// tb/tb_path_metric_bank.sv - scoreboard bench for path_metric_bank (default and 64x10 instances)
module tb_path_metric_bank;

`ifdef PATH_METRIC_NORM_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int BN = 64;
    localparam int BW = 10;

    typedef struct {
        logic [31:0] pm;
        logic [1:0]  st;
        logic [7:0]  mpm;
        logic        evt;
        logic [15:0] cnt;
    } exp_a_t;

    typedef struct {
        logic [BN*BW-1:0] pm;
        logic [5:0]       st;
        logic [BW-1:0]    mpm;
        logic             evt;
        logic [15:0]      cnt;
    } exp_b_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 0, a_valid_in = 0;
    logic [31:0] a_pm_in = '0;
    logic [31:0] a_pm;
    logic        a_valid, a_evt;
    logic [1:0]  a_st;
    logic [7:0]  a_mpm;
    logic [15:0] a_cnt;

    logic             b_start = 0, b_valid_in = 0;
    logic [BN*BW-1:0] b_pm_in = '0;
    logic [BN*BW-1:0] b_pm;
    logic             b_valid, b_evt;
    logic [5:0]       b_st;
    logic [BW-1:0]    b_mpm;
    logic [15:0]      b_cnt;

    path_metric_bank u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_valid(a_valid_in), .i_pm(a_pm_in),
        .o_pm(a_pm), .o_valid(a_valid), .o_min_state(a_st), .o_min_pm(a_mpm),
        .o_norm_evt(a_evt), .o_norm_cnt(a_cnt)
    );

    path_metric_bank #(.NUM_STATES(BN), .PM_WIDTH(BW)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_valid(b_valid_in), .i_pm(b_pm_in),
        .o_pm(b_pm), .o_valid(b_valid), .o_min_state(b_st), .o_min_pm(b_mpm),
        .o_norm_evt(b_evt), .o_norm_cnt(b_cnt)
    );

    int checks = 0;
    int failures = 0;
    exp_a_t qa[$];
    exp_b_t qb[$];
    int model_a_cnt = 0;
    int model_b_cnt = 0;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (a_valid !== 1'b0) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_valid actual=%b required=0", a_valid);
            end else begin
                exp_a_t e;
                e = qa.pop_front();
                check("a_pm", a_pm, e.pm);
                check("a_min_state", a_st, e.st);
                check("a_min_pm", a_mpm, e.mpm);
                check("a_norm_evt", a_evt, e.evt);
                check("a_norm_cnt", a_cnt, e.cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (b_valid !== 1'b0) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_valid actual=%b required=0", b_valid);
            end else begin
                exp_b_t e;
                e = qb.pop_front();
                check("b_pm", b_pm, e.pm);
                check("b_min_state", b_st, e.st);
                check("b_min_pm", b_mpm, e.mpm);
                check("b_norm_evt", b_evt, e.evt);
                check("b_norm_cnt", b_cnt, e.cnt);
            end
        end
    end

    task automatic drive_a(input logic v, input logic s, input logic [31:0] pm);
        @(negedge clk);
        a_valid_in = v;
        a_start    = s;
        a_pm_in    = pm;
    endtask

    task automatic drive_b(input logic v, input logic s, input logic [BN*BW-1:0] pm);
        @(negedge clk);
        b_valid_in = v;
        b_start    = s;
        b_pm_in    = pm;
    endtask

    task automatic push_a(input logic [31:0] pm, input logic [1:0] st, input logic [7:0] mpm, input logic evt);
        exp_a_t e;
        if (evt) model_a_cnt++;
        e.pm  = pm;
        e.st  = st;
        e.mpm = mpm;
        e.evt = evt;
        e.cnt = CNT_EN ? 16'(model_a_cnt) : 16'd0;
        qa.push_back(e);
    endtask

    function automatic exp_b_t model_b(input logic [BN*BW-1:0] v, input int cnt);
        exp_b_t e;
        logic [BW-1:0] m;
        int idx;
        m = v[BW-1:0];
        idx = 0;
        for (int k = 1; k < BN; k++) begin
            if (v[k*BW +: BW] < m) begin
                m = v[k*BW +: BW];
                idx = k;
            end
        end
        e.evt = (m >= BW'(512));
        for (int k = 0; k < BN; k++)
            e.pm[k*BW +: BW] = e.evt ? v[k*BW +: BW] - m : v[k*BW +: BW];
        e.st  = 6'(idx);
        e.mpm = e.evt ? '0 : m;
        e.cnt = CNT_EN ? 16'(cnt) : 16'd0;
        return e;
    endfunction

    logic [BN*BW-1:0] b_init;
    logic [BN*BW-1:0] vec;

    initial begin
        b_init = '1;
        b_init[BW-1:0] = '0;

        repeat (2) @(negedge clk);
        check("rst_pm", a_pm, 32'hFFFFFF00);
        check("rst_valid", a_valid, 1'b0);
        check("rst_min_state", a_st, 2'd0);
        check("rst_min_pm", a_mpm, 8'd0);
        check("rst_norm_evt", a_evt, 1'b0);
        check("rst_norm_cnt", a_cnt, 16'd0);
        check("rst_b_pm", b_pm, b_init);
        rst_n = 1'b1;

        drive_a(1, 0, 32'h01020304);
        drive_a(0, 0, 32'h0);
        check("idle_valid_ignored", a_valid, 1'b0);
        check("idle_pm_hold", a_pm, 32'hFFFFFF00);

        drive_a(0, 1, 32'h0);
        drive_a(0, 0, 32'h0);
        check("start_pm", a_pm, 32'hFFFFFF00);
        check("start_valid", a_valid, 1'b0);
        check("start_min_state", a_st, 2'd0);

        push_a(32'h05030703, 2'd0, 8'h03, 1'b0);
        drive_a(1, 0, 32'h05030703);
        push_a(32'h0B001B3B, 2'd2, 8'h00, 1'b1);
        drive_a(1, 0, 32'h9085A0C0);
        drive_a(0, 0, 32'h0);
        drive_a(0, 0, 32'h0);
        check("hold_valid", a_valid, 1'b0);
        check("hold_pm", a_pm, 32'h0B001B3B);
        check("hold_norm_evt", a_evt, 1'b0);

        drive_a(1, 1, 32'hFFFFFFFF);
        model_a_cnt = 0;
        drive_a(0, 0, 32'h0);
        check("restart_pm", a_pm, 32'hFFFFFF00);
        check("restart_valid", a_valid, 1'b0);
        check("restart_min_pm", a_mpm, 8'd0);
        check("restart_norm_cnt", a_cnt, 16'd0);

        push_a(32'h10203040, 2'd3, 8'h10, 1'b0);
        drive_a(1, 0, 32'h10203040);
        push_a(32'h00000000, 2'd0, 8'h00, 1'b1);
        drive_a(1, 0, 32'h80808080);
        push_a(32'h11111111, 2'd0, 8'h11, 1'b0);
        drive_a(1, 0, 32'h11111111);
        drive_a(0, 0, 32'h0);

        #2 rst_n = 1'b0;
        model_a_cnt = 0;
        #1;
        check("arst_pm", a_pm, 32'hFFFFFF00);
        check("arst_valid", a_valid, 1'b0);
        check("arst_min_state", a_st, 2'd0);
        check("arst_min_pm", a_mpm, 8'd0);
        check("arst_norm_cnt", a_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1, 0, 32'h22222222);
        drive_a(0, 0, 32'h0);
        check("arst_idle_ignored", a_valid, 1'b0);
        check("arst_idle_pm", a_pm, 32'hFFFFFF00);
        drive_a(0, 1, 32'h0);
        push_a(32'h04030201, 2'd0, 8'h01, 1'b0);
        drive_a(1, 0, 32'h04030201);
        drive_a(0, 0, 32'h0);
        drive_a(0, 0, 32'h0);

        drive_b(0, 1, '0);
        model_b_cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                drive_b(0, 0, '0);
            end else begin
                int base;
                exp_b_t e;
                base = $urandom_range(0, 900);
                for (int k = 0; k < BN; k++)
                    vec[k*BW +: BW] = BW'(base + $urandom_range(0, 123));
                e = model_b(vec, 0);
                if (e.evt && model_b_cnt < 65535) model_b_cnt++;
                e.cnt = CNT_EN ? 16'(model_b_cnt) : 16'd0;
                qb.push_back(e);
                drive_b(1, 0, vec);
            end
        end
        drive_b(0, 0, '0);

        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++)
            @(negedge clk);
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
